// File: rtl/pool_window_stream.sv
// pool_window_stream
// ------------------
// Pooling stage between a feature-map producer and the next layer's input
// buffer. A whole N_IN-element vector is captured in one valid/ready
// handshake. Consecutive non-overlapping windows of WIN elements are then
// reduced by max or floor-average, and one result is streamed per accepted
// output beat. All flow control is by valid/ready; there is no clock gating.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   in_valid   input vector valid
//   in_ready   block can accept a vector (IDLE and out of reset)
//   in_data    flat vector, element j = in_data[j*DATA_W +: DATA_W]
//   in_mode    0 = max, 1 = average; sampled together with the vector
//   out_valid  pool_out holds a valid result
//   out_ready  downstream accepts the current result
//   pool_out   pooled value (signed, DATA_W bits)
//   out_last   result belongs to the final window of the vector
//   busy       high while a vector is being processed (FILL or RUN)
module pool_window_stream #(
  parameter int DATA_W  = 16,
  parameter int N_IN    = 64,
  parameter int WIN     = 4,
  parameter int REVERSE = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N_IN*DATA_W-1:0]   in_data,
  input  logic                     in_mode,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        pool_out,
  output logic                     out_last,
  output logic                     busy
);

  localparam int N_WIN = N_IN / WIN;
  localparam int LW    = $clog2(WIN);
  localparam int KW    = (N_WIN > 1) ? $clog2(N_WIN) : 1;
  localparam int SUM_W = DATA_W + LW;
  localparam logic [KW-1:0] K_LAST = KW'(N_WIN - 1);

  // Reject parameter sets the window arithmetic cannot handle.
  if ((N_IN % WIN) != 0) begin : g_bad_n_in
    $error("pool_window_stream: N_IN must be a multiple of WIN");
  end
  if (WIN < 2) begin : g_bad_win_min
    $error("pool_window_stream: WIN must be at least 2");
  end
  if ((WIN & (WIN - 1)) != 0) begin : g_bad_win_pow2
    $error("pool_window_stream: WIN must be a power of two");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t state_r;
  state_t state_nxt_s;

  // Buffer organised as windows so a window is selected by the index alone.
  logic [N_WIN-1:0][WIN-1:0][DATA_W-1:0] win_buf_r;
  logic [N_WIN-1:0][WIN-1:0][DATA_W-1:0] cap_s;
  logic [WIN-1:0][DATA_W-1:0]            win_s;

  logic [KW-1:0]            k_r;
  logic [KW-1:0]            sel_s;
  logic                     mode_r;
  logic                     rdy_r;
  logic                     valid_r;
  logic                     last_r;
  logic                     busy_r;
  logic [DATA_W-1:0]        pool_r;

  logic                     cap_fire_s;
  logic                     beat_s;
  logic [DATA_W-1:0]        max_s;
  logic signed [SUM_W-1:0]  sum_s;
  logic [DATA_W-1:0]        avg_s;
  logic [DATA_W-1:0]        red_s;

  // in_ready must read 0 for as long as rst is held low, so the registered
  // ready flag is additionally gated by rst itself.
  assign in_ready  = rdy_r & rst;
  assign out_valid = valid_r;
  assign out_last  = last_r;
  assign pool_out  = pool_r;
  assign busy      = busy_r;

  assign cap_fire_s = in_valid & rdy_r & (state_r == S_IDLE);
  assign beat_s     = valid_r & out_ready & (state_r == S_RUN);

  // Reorder the incoming flat vector into window-major buffer layout.
  always_comb begin
    cap_s = '0;
    for (int w = 0; w < N_WIN; w++) begin
      for (int e = 0; e < WIN; e++) begin
        cap_s[w][e] = in_data[((REVERSE != 0) ? (N_IN - 1 - (w * WIN + e))
                                              : (w * WIN + e)) * DATA_W +: DATA_W];
      end
    end
  end

  // Window to reduce: 0 while filling, k+1 while streaming. At the final
  // window the result is not used, so index 0 keeps the select in range.
  always_comb begin
    sel_s = '0;
    if ((state_r == S_RUN) && (k_r != K_LAST)) begin
      sel_s = k_r + KW'(1);
    end else begin
      sel_s = '0;
    end
  end

  // Combinational max / floor-average of the selected window.
  always_comb begin
    win_s = win_buf_r[sel_s];
    max_s = win_s[0];
    sum_s = '0;
    for (int i = 1; i < WIN; i++) begin
      if ($signed(win_s[i]) > $signed(max_s)) begin
        max_s = win_s[i];
      end else begin
        max_s = max_s;
      end
    end
    // Sum is DATA_W+log2(WIN) bits wide, so it can never overflow; the
    // arithmetic shift rounds toward minus infinity.
    for (int i = 0; i < WIN; i++) begin
      sum_s = sum_s + SUM_W'($signed(win_s[i]));
    end
    avg_s = DATA_W'(sum_s >>> LW);
    if (mode_r) begin
      red_s = avg_s;
    end else begin
      red_s = max_s;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (cap_fire_s) begin
          state_nxt_s = S_FILL;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_FILL: begin
        state_nxt_s = S_RUN;
      end
      S_RUN: begin
        if (beat_s && (k_r == K_LAST)) begin
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_RUN;
        end
      end
      default: begin
        state_nxt_s = S_IDLE;
      end
    endcase
  end

  // Capture buffer, window index and all registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win_buf_r <= '0;
      k_r       <= '0;
      mode_r    <= 1'b0;
      rdy_r     <= 1'b1;
      valid_r   <= 1'b0;
      last_r    <= 1'b0;
      busy_r    <= 1'b0;
      pool_r    <= '0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (cap_fire_s) begin
            win_buf_r <= cap_s;
            mode_r    <= in_mode;
            k_r       <= '0;
            rdy_r     <= 1'b0;
            busy_r    <= 1'b1;
          end
        end
        S_FILL: begin
          pool_r  <= red_s;
          valid_r <= 1'b1;
          last_r  <= (N_WIN == 1) ? 1'b1 : 1'b0;
        end
        S_RUN: begin
          if (beat_s) begin
            if (k_r == K_LAST) begin
              // pool_out deliberately keeps the final value.
              valid_r <= 1'b0;
              last_r  <= 1'b0;
              rdy_r   <= 1'b1;
              busy_r  <= 1'b0;
            end else begin
              k_r    <= sel_s;
              pool_r <= red_s;
              last_r <= (sel_s == K_LAST) ? 1'b1 : 1'b0;
            end
          end
        end
        default: begin
          valid_r <= 1'b0;
          last_r  <= 1'b0;
          rdy_r   <= 1'b1;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pool_window_stream.sv
// Directed bench for pool_window_stream: a default instance (64 x 16-bit,
// WIN=4, REVERSE=1) and a small instance (8 elements, WIN=2, REVERSE=0).
module tb_pool_window_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic          in_valid0, in_ready0, in_mode0, out_valid0, out_ready0, out_last0, busy0;
  logic [1023:0] in_data0;
  logic [15:0]   pool_out0;

  logic          in_valid1, in_ready1, in_mode1, out_valid1, out_ready1, out_last1, busy1;
  logic [127:0]  in_data1;
  logic [15:0]   pool_out1;

  int checks = 0;
  int errors = 0;

  pool_window_stream u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0),
    .in_data(in_data0), .in_mode(in_mode0), .out_valid(out_valid0),
    .out_ready(out_ready0), .pool_out(pool_out0), .out_last(out_last0), .busy(busy0)
  );

  pool_window_stream #(.DATA_W(16), .N_IN(8), .WIN(2), .REVERSE(0)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_data(in_data1), .in_mode(in_mode1), .out_valid(out_valid1),
    .out_ready(out_ready1), .pool_out(pool_out1), .out_last(out_last1), .busy(busy1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // element j = base + j
  task automatic ramp(input int base);
    for (int j = 0; j < 64; j++) in_data0[j*16 +: 16] = 16'(base + j);
  endtask

  // Called one step after a capture edge (FILL). Expects 16 results
  // top, top-4, ..., top-60 on consecutive cycles with out_ready=1.
  task automatic stream(input int top);
    chk("fill_valid", {31'd0, out_valid0}, 32'd0);
    chk("fill_busy", {31'd0, busy0}, 32'd1);
    chk("fill_in_ready", {31'd0, in_ready0}, 32'd0);
    tick;
    for (int k = 0; k < 16; k++) begin
      chk("stream_pool", {16'd0, pool_out0}, {16'd0, 16'(top - 4 * k)});
      chk("stream_valid", {31'd0, out_valid0}, 32'd1);
      chk("stream_last", {31'd0, out_last0}, (k == 15) ? 32'd1 : 32'd0);
      tick;
    end
    chk("end_valid", {31'd0, out_valid0}, 32'd0);
    chk("end_in_ready", {31'd0, in_ready0}, 32'd1);
    chk("end_busy", {31'd0, busy0}, 32'd0);
    chk("end_pool_hold", {16'd0, pool_out0}, {16'd0, 16'(top - 60)});
  endtask

  logic [15:0] exp5 [4];
  logic [3:0]  pat;
  int          e;
  int          cyc;
  logic        hs;

  initial begin
    rst = 1'b0;
    in_valid0 = 1'b0; in_mode0 = 1'b0; out_ready0 = 1'b1; in_data0 = '0;
    in_valid1 = 1'b0; in_mode1 = 1'b0; out_ready1 = 1'b1; in_data1 = '0;
    tick;
    tick;
    chk("rst_in_ready", {31'd0, in_ready0}, 32'd0);
    chk("rst_valid", {31'd0, out_valid0}, 32'd0);
    chk("rst_pool", {16'd0, pool_out0}, 32'd0);
    chk("rst_last", {31'd0, out_last0}, 32'd0);
    chk("rst_busy", {31'd0, busy0}, 32'd0);
    rst = 1'b1;
    #1;
    chk("rel_in_ready", {31'd0, in_ready0}, 32'd1);

    // Max mode, element j = j: 63, 59, ..., 3
    ramp(0);
    in_mode0 = 1'b0;
    in_valid0 = 1'b1;
    tick;
    in_valid0 = 1'b0;
    stream(63);

    // Average mode: {-1,-2,-3,-3} -> -3, {5,6,7,8} -> 6, rest 0
    in_data0 = '0;
    in_data0[63*16 +: 16] = 16'hFFFF;
    in_data0[62*16 +: 16] = 16'hFFFE;
    in_data0[61*16 +: 16] = 16'hFFFD;
    in_data0[60*16 +: 16] = 16'hFFFD;
    in_data0[59*16 +: 16] = 16'd5;
    in_data0[58*16 +: 16] = 16'd6;
    in_data0[57*16 +: 16] = 16'd7;
    in_data0[56*16 +: 16] = 16'd8;
    in_mode0 = 1'b1;
    in_valid0 = 1'b1;
    tick;
    in_valid0 = 1'b0;
    in_mode0 = 1'b0;
    chk("avg_fill_valid", {31'd0, out_valid0}, 32'd0);
    tick;
    chk("avg_w0", {16'd0, pool_out0}, 32'h0000FFFD);
    chk("avg_w0_valid", {31'd0, out_valid0}, 32'd1);
    tick;
    chk("avg_w1", {16'd0, pool_out0}, 32'd6);
    tick;
    for (int k = 2; k < 16; k++) begin
      chk("avg_rest", {16'd0, pool_out0}, 32'd0);
      chk("avg_last", {31'd0, out_last0}, (k == 15) ? 32'd1 : 32'd0);
      tick;
    end
    chk("avg_end_valid", {31'd0, out_valid0}, 32'd0);

    // Backpressure: out_ready pattern 1,0,0,1 repeating
    ramp(0);
    in_valid0 = 1'b1;
    tick;
    in_valid0 = 1'b0;
    pat = 4'b1001;
    e = 0;
    cyc = 0;
    while (e < 16 && cyc < 100) begin
      if (out_valid0) begin
        chk("bp_pool", {16'd0, pool_out0}, {16'd0, 16'(63 - 4 * e)});
        chk("bp_last", {31'd0, out_last0}, (e == 15) ? 32'd1 : 32'd0);
      end
      out_ready0 = pat[cyc % 4];
      hs = out_valid0 & out_ready0;
      tick;
      if (hs) e++;
      cyc++;
    end
    out_ready0 = 1'b1;
    chk("bp_count", 32'(e), 32'd16);
    chk("bp_end_valid", {31'd0, out_valid0}, 32'd0);

    // Reset in the middle of a vector, after the 5th beat
    ramp(200);
    in_valid0 = 1'b1;
    tick;
    in_valid0 = 1'b0;
    tick;
    chk("mr_first", {16'd0, pool_out0}, 32'd263);
    repeat (5) tick;
    chk("mr_sixth", {16'd0, pool_out0}, 32'd243);
    #2;
    rst = 1'b0;
    #1;
    chk("mr_valid", {31'd0, out_valid0}, 32'd0);
    chk("mr_pool", {16'd0, pool_out0}, 32'd0);
    chk("mr_last", {31'd0, out_last0}, 32'd0);
    chk("mr_in_ready", {31'd0, in_ready0}, 32'd0);
    chk("mr_busy", {31'd0, busy0}, 32'd0);
    tick;
    rst = 1'b1;
    #1;
    chk("mr_rel_in_ready", {31'd0, in_ready0}, 32'd1);
    chk("mr_rel_valid", {31'd0, out_valid0}, 32'd0);
    ramp(100);
    in_valid0 = 1'b1;
    tick;
    in_valid0 = 1'b0;
    stream(163);

    // Small instance, REVERSE=0, WIN=2
    in_data1 = {16'h8000, 16'h7FFF, 16'hFFFE, 16'hFFFF,
                16'h0003, 16'h0003, 16'hFFF8, 16'h0007};
    exp5[0] = 16'h0007; exp5[1] = 16'h0003; exp5[2] = 16'hFFFF; exp5[3] = 16'h7FFF;
    in_valid1 = 1'b1;
    tick;
    in_valid1 = 1'b0;
    chk("s_fill_valid", {31'd0, out_valid1}, 32'd0);
    tick;
    for (int k = 0; k < 4; k++) begin
      chk("s_pool", {16'd0, pool_out1}, {16'd0, exp5[k]});
      chk("s_last", {31'd0, out_last1}, (k == 3) ? 32'd1 : 32'd0);
      tick;
    end
    chk("s_end_valid", {31'd0, out_valid1}, 32'd0);
    chk("s_end_in_ready", {31'd0, in_ready1}, 32'd1);

    // Back-to-back: in_valid held, mode flipped while A streams
    ramp(0);
    in_mode0 = 1'b0;
    in_valid0 = 1'b1;
    tick;
    ramp(1000);
    in_mode0 = 1'b1;
    stream(63);
    tick;
    in_valid0 = 1'b0;
    in_mode0 = 1'b0;
    // B is averaged: {1063-4k .. 1060-4k} -> floor(1061.5-4k) = 1061-4k
    stream(1061);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
